// File: rtl/q88_pkg.sv
// q88_pkg: shared Q8.8 widths, constants and the accumulator state encoding
package q88_pkg;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam logic [DATA_W-1:0] Q88_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] Q88_MIN = 16'h8000;
  localparam logic [DATA_W-1:0] Q88_ONE = 16'h0100;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/q88_sat.sv
// q88_sat: combinational wide-to-narrow two's complement saturator with flag
module q88_sat #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             sat
);
  logic [IN_W-OUT_W:0] top;
  always_comb begin
    top  = din[IN_W-1:OUT_W-1];
    sat  = !((&top) || !(|top));
    dout = !sat ? din[OUT_W-1:0] :
           din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end
endmodule

// File: rtl/q88_accumulator.sv
// q88_accumulator: guarded sum of n Q8.8 products onto x_n with saturated, sticky-overflow result
module q88_accumulator
  import q88_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int GUARD_W = 4,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] init_value,
  input  logic [CNT_W-1:0]  n_terms,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_product,
  input  logic              in_ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_ovf,
  output logic              busy
);
  localparam int ACC_W = DATA_W + GUARD_W;
  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               ovf, ovf_nxt;
  logic               accept, load;
  logic [DATA_W-1:0]  sat_val;
  logic               sat_flag;
  always_comb begin
    load      = (state == IDLE) && start;
    accept    = (state == ACCUM) && in_valid;
    acc_nxt   = load   ? {{GUARD_W{init_value[DATA_W-1]}}, init_value} :
                accept ? acc + {{GUARD_W{in_product[DATA_W-1]}}, in_product} : acc;
    ovf_nxt   = load ? 1'b0 : accept ? (ovf | in_ovf) : ovf;
    cnt_nxt   = load ? n_terms : accept ? cnt - CNT_W'(1) : cnt;
    state_nxt = state == IDLE  ? (start ? ((n_terms != '0) ? ACCUM : DONE) : IDLE) :
                state == ACCUM ? ((accept && cnt == CNT_W'(1)) ? DONE : ACCUM) :
                out_ready ? IDLE : DONE;
  end
  // saturate the next-cycle sum so the result register is valid on DONE entry
  q88_sat #(.IN_W(ACC_W), .OUT_W(DATA_W)) u_sat (
    .din  (acc_nxt),
    .dout (sat_val),
    .sat  (sat_flag)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      out_result <= '0;
      out_ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
      if (state != DONE && state_nxt == DONE) begin
        out_result <= sat_val;
        out_ovf    <= ovf_nxt | sat_flag;
      end
    end
  end
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_q88_accumulator.sv
// tb_q88_accumulator: table vectors, corner sequences and random steps against an integer-sum model
module tb_q88_accumulator;
  logic        clk = 0, reset = 0, start = 0, in_valid = 0, in_ovf = 0, out_ready = 0;
  logic [15:0] init_value = 0, in_product = 0;
  logic [3:0]  n_terms = 0;
  logic        in_ready, out_valid, out_ovf, busy;
  logic [15:0] out_result;
  int          errs = 0, checks = 0;
  logic [15:0] prods [16];
  logic        flags [16];

  q88_accumulator dut (
    .clk(clk), .reset(reset), .start(start), .init_value(init_value), .n_terms(n_terms),
    .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product), .in_ovf(in_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_ovf(out_ovf),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]      init;
    logic [3:0]       n;
    logic [3:0][15:0] p;
    logic [3:0]       f;
    logic [15:0]      er;
    logic             eo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [15:0] init, input int n, output logic [15:0] r, output logic o);
    int s;
    s = $signed(init);
    o = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = s + $signed(prods[i]);
      o = o | flags[i];
    end
    if (s > 32767) begin r = 16'h7FFF; o = 1'b1; end
    else if (s < -32768) begin r = 16'h8000; o = 1'b1; end
    else r = s[15:0];
  endfunction

  task automatic run_step(input logic [15:0] init, input int n, input int gap_max, input int hold,
                          output logic [15:0] r, output logic o);
    int k, g;
    @(posedge clk); #1;
    start = 1; init_value = init; n_terms = n[3:0];
    @(posedge clk); #1;
    start = 0;
    if (n == 0) chk("zero_no_ready", {31'd0, in_ready}, 0);
    for (int i = 0; i < n; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (g) begin in_valid = 0; @(posedge clk); #1; end
      chk("accum_ready", {31'd0, in_ready}, 1);
      in_valid = 1; in_product = prods[i]; in_ovf = flags[i];
      @(posedge clk); #1;
    end
    in_valid = 0; in_ovf = 0;
    if (gap_max == 0) chk("latency_valid", {31'd0, out_valid}, 1);
    k = 0;
    while (!out_valid && k < 40) begin @(posedge clk); #1; k++; end
    if (!out_valid) chk("timeout", 0, 1);
    r = out_result; o = out_ovf;
    chk("done_busy_noready", {30'd0, busy, in_ready}, 32'h2);
    repeat (hold) begin
      start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("hold_stable", {15'd0, out_valid, out_ovf, out_result}, {15'd0, 1'b1, o, r});
    end
    start = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("released", {30'd0, out_valid, busy}, 0);
  endtask

  initial begin
    vec_t        tbl [6];
    logic [15:0] r, er, init;
    logic        o, eo;
    int          n;
    tbl[0] = '{16'h0100, 4'd3, {16'h0, 16'h0020, 16'h0040, 16'h0080}, 4'b0000, 16'h01E0, 1'b0};
    tbl[1] = '{16'hFF00, 4'd0, {16'h0, 16'h0, 16'h0, 16'h0},          4'b0000, 16'hFF00, 1'b0};
    tbl[2] = '{16'h7000, 4'd2, {16'h0, 16'h0, 16'h4000, 16'h4000},    4'b0000, 16'h7FFF, 1'b1};
    tbl[3] = '{16'h7000, 4'd2, {16'h0, 16'h0, 16'hB000, 16'h4000},    4'b0000, 16'h6000, 1'b0};
    tbl[4] = '{16'h8000, 4'd1, {16'h0, 16'h0, 16'h0, 16'hF000},       4'b0000, 16'h8000, 1'b1};
    tbl[5] = '{16'h0000, 4'd2, {16'h0, 16'h0, 16'h0100, 16'h0100},    4'b0001, 16'h0200, 1'b1};

    #12;
    chk("reset_outputs", {13'd0, in_ready, out_valid, out_ovf, busy, out_result}, 0);
    @(posedge clk); #1;
    reset = 1;

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 4; j++) begin prods[j] = tbl[i].p[j]; flags[j] = tbl[i].f[j]; end
      run_step(tbl[i].init, int'(tbl[i].n), 0, 0, r, o);
      chk($sformatf("vec%0d_result", i), {16'd0, r}, {16'd0, tbl[i].er});
      chk($sformatf("vec%0d_ovf", i), {31'd0, o}, {31'd0, tbl[i].eo});
    end

    // gapped valid 1,0,0,1 then a 5-cycle stall with start pulses in DONE
    in_valid = 1;
    @(posedge clk); #1;
    chk("idle_no_ready", {31'd0, in_ready}, 0);
    in_valid = 0;
    start = 1; init_value = 16'h0100; n_terms = 4'd2;
    @(posedge clk); #1;
    start = 0; in_valid = 1; in_product = 16'h0010;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("gap_waiting", {30'd0, in_ready, out_valid}, 32'h2);
    end
    in_valid = 1; in_product = 16'h0110;
    @(posedge clk); #1;
    in_valid = 0;
    chk("gap_valid", {31'd0, out_valid}, 1);
    repeat (5) begin
      start = 1; init_value = 16'h1234; n_terms = 4'd0;
      @(posedge clk); #1;
      chk("stall_stable", {14'd0, out_valid, busy, out_ovf, out_result}, {14'd0, 1'b1, 1'b1, 1'b0, 16'h0220});
    end
    start = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("gap_release", {30'd0, out_valid, busy}, 0);
    @(posedge clk); #1;
    chk("gap_idle", {30'd0, out_valid, busy}, 0);

    // reset mid-step after one of three products
    start = 1; init_value = 16'h0100; n_terms = 4'd3;
    @(posedge clk); #1;
    start = 0; in_valid = 1; in_product = 16'h0300;
    @(posedge clk); #1;
    in_valid = 0;
    reset = 0;
    #1;
    chk("midreset_outputs", {13'd0, in_ready, out_valid, out_ovf, busy, out_result}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk); #1;
    chk("post_reset_idle", {30'd0, in_ready, busy}, 0);
    prods[0] = 16'h0100; flags[0] = 1'b0;
    run_step(16'h0100, 1, 0, 0, r, o);
    chk("post_reset_result", {15'd0, o, r}, {15'd0, 1'b0, 16'h0200});

    for (int t = 0; t < 40; t++) begin
      n = int'($urandom_range(0, 15));
      init = 16'($urandom);
      for (int j = 0; j < 16; j++) begin
        prods[j] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($signed(12'($urandom)));
        flags[j] = ($urandom_range(0, 7) == 0);
      end
      model(init, n, er, eo);
      run_step(init, n, 2, int'($urandom_range(0, 2)), r, o);
      chk("rand_result", {15'd0, o, r}, {15'd0, eo, er});
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
